vga_frame_buf: RTL and testbench
================================

# vga_frame_buf

Parametrised single-clock frame buffer between the NIOS host port and the VGA pixel pipeline. Accepts packed pixel words over a valid/ready handshake, unpacks them into a DEPTH-pixel image and streams pixels to the display whenever `active` is high, wrapping at the end of the frame. Adds reset, a reload request, frame-start marking and optional double buffering, so a new image can be loaded without tearing the displayed one.

## Interface
- `PIX_W`, 4: bits per pixel; legal values 1, 2, 4 or 8.
- `DATA_W`, 32: host word width; must be a multiple of 8.
- `DEPTH`, 4096: pixels per frame; must be a multiple of PPW = DATA_W/PIX_W.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in DATA_W: packed pixel word from host.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block can accept a word.
- `reload` in 1: one-cycle pulse that restarts loading of a new image.
- `active` in 1: VGA visible region; advances the read pointer.
- `img_ready` out 1: a complete image is available for display.
- `pix_value` out PIX_W: current display pixel.
- `pix_valid` out 1: `pix_value` was updated this cycle.
- `frame_start` out 1: `pix_value` is pixel 0 of the frame.

## Operation
- Storage: DEPTH/PPW words of DATA_W per bank. The read side selects a lane by pixel index mod PPW.
- Lane order: bytes are ordered from least significant (byte 0 holds the first pixels). Within a byte, the most significant pixel comes first. With PIX_W=4, word 0x87654321 gives pixels 2,1,4,3,6,5,8,7.
- A word is accepted on a clock edge where `in_valid && in_ready`. It is written to word address `wr_ptr` and `wr_ptr` increments.
- Write FSM:
  - LOAD: `in_ready`=1. Accepting the last word (`wr_ptr`=DEPTH/PPW-1) moves the FSM to FULL and resets `wr_ptr` to 0.
  - FULL: `in_ready`=0.
  - `reload` in any state → LOAD with `wr_ptr`=0. If a word is offered in the same cycle, `reload` wins and the word is discarded.
- Read side:
  - IDLE while `img_ready`=0.
  - STREAM once `img_ready`=1. Each cycle with `active`=1 outputs pixel `rd_ptr` and increments `rd_ptr`, wrapping from DEPTH-1 to 0.
  - `active`=0 holds `rd_ptr` and `pix_value`.
- Without double buffering, `reload` clears `img_ready` and returns the read side to IDLE with `rd_ptr`=0.
- Counters: `wr_ptr` is clog2(DEPTH/PPW) bits and `rd_ptr` is clog2(DEPTH) bits. Both wrap explicitly at the terminal value, never by overflow.

## Timing
- Reset values: `in_ready`=0, `img_ready`=0, `pix_value`=0, `pix_valid`=0, `frame_start`=0. Both FSMs, all pointers and the bank select are 0 at reset.
- `in_ready` rises on the first clock edge after `rst_n` deasserts.
- Reset mid-load discards the partial image. Memory contents are not cleared.
- `img_ready` rises one cycle after the last word is accepted.
- The first `active` cycle with `img_ready`=1 produces pixel 0 at the next edge.
- Read latency is one cycle: `active` sampled high at edge N gives `pix_value` and `pix_valid`=1 after edge N.
- `frame_start`=1 together with the `pix_valid` of pixel 0.
- `pix_valid` is 0 whenever `active` was 0 at the previous edge.

## Configuration
- Macro: `VGA_FRAME_BUF_DOUBLE_BUF_EN`.
- Defined:
  - Two banks: a front bank is displayed while the back bank loads.
  - Completing a load in LOAD sets a pending-swap flag, and the FSM waits in FULL with `in_ready`=0.
  - The swap happens on the edge where pixel DEPTH-1 is output with the flag set. The next displayed pixel 0 comes from the new bank, and the write FSM returns to LOAD for the other bank.
  - The first completed image swaps immediately and sets `img_ready`. `img_ready` then stays 1 until reset.
  - `reload` restarts only the back-bank load and clears the pending flag; display is uninterrupted.
- Undefined: one bank only, with the behaviour described in Operation.

## Test plan
- Reset check, PIX_W=4, DEPTH=64: hold `rst_n`=0 for 3 cycles → all outputs 0; `in_ready`=1 one cycle after release.
- Load 8 words 0x87654321 with `active`=1 → `img_ready` rises the cycle after word 8. Output sequence is 2,1,4,3,6,5,8,7 repeated. `frame_start` is set on pixels 0 and 64; the pointer wraps after 64 pixels.
- Toggle `active` 1,0,0,1 while streaming → `pix_value` holds across the gap and `pix_valid` follows the delayed pattern.
- `reload` asserted together with an offered word at word 3 → that word is dropped, `wr_ptr`=0, and the image is complete only after 8 further words.
- PIX_W=8, DATA_W=32, word 0x44332211 → pixels 0x11,0x22,0x33,0x44.
- DOUBLE_BUF_EN: display image A (all 0x1) and load image B (all 0x2) mid-frame → output stays 0x1 until pixel 63, then pixel 0 onward is 0x2 with `frame_start`=1. `in_ready` is 0 between load completion and the swap.

Source files
------------

// File: rtl/vga_frame_buf_if.sv
// Host-side pixel word channel of the frame buffer: packed word plus valid/ready.
// The host drives the master side, the frame buffer sits on the slave side.
interface vga_frame_buf_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/vga_frame_buf.sv
// Frame buffer between host word stream and VGA pixel pipeline; unpacks words into pixels.
// Define VGA_FRAME_BUF_DOUBLE_BUF_EN for two banks with tear-free swap at end of frame.
module vga_frame_buf #(
   parameter int PIX_W  = 4,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4096
) (
   input  logic             clk,
   input  logic             rst_n,
   vga_frame_buf_if.slave   host,
   input  logic             reload,
   input  logic             active,
   output logic             img_ready,
   output logic [PIX_W-1:0] pix_value,
   output logic             pix_valid,
   output logic             frame_start
);
   localparam int PPW    = DATA_W / PIX_W;
   localparam int PPB    = 8 / PIX_W;
   localparam int WORDS  = DEPTH / PPW;
   localparam int WA_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int RA_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
`ifdef VGA_FRAME_BUF_DOUBLE_BUF_EN
   localparam int NBANK  = 2;
`else
   localparam int NBANK  = 1;
`endif
   localparam int AD_W   = WA_W + NBANK - 1;
   localparam logic [WA_W-1:0] WR_LAST = WA_W'(WORDS - 1);
   localparam logic [RA_W-1:0] RD_LAST = RA_W'(DEPTH - 1);

   typedef enum logic {W_LOAD = 1'b0, W_FULL = 1'b1} wr_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_STREAM = 1'b1} rd_state_t;

   wr_state_t         wr_state_reg;
   rd_state_t         rd_state_reg;
   logic [WA_W-1:0]   wr_ptr_reg;
   logic [RA_W-1:0]   rd_ptr_reg;
   logic              in_ready_reg;
   logic              img_ready_reg;
   logic              pix_valid_reg;
   logic              frame_start_reg;
   logic              shown_reg;
   logic [LANE_W-1:0] lane_reg;
   logic [DATA_W-1:0] rd_word_reg;
`ifdef VGA_FRAME_BUF_DOUBLE_BUF_EN
   logic              bank_reg;
   logic              pending_reg;
`endif

   logic [DATA_W-1:0] mem [NBANK*WORDS];

   logic              accept;
   logic              last_word;
   logic              last_pix;
   logic              rd_en;
   logic [WA_W-1:0]   rd_word_idx;
   logic [LANE_W-1:0] rd_lane;
   logic [AD_W-1:0]   wr_addr;
   logic [AD_W-1:0]   rd_addr;
   logic [PIX_W-1:0]  lanes [PPW];

   // reload has priority over a word offered in the same cycle
   assign accept      = host.in_valid && in_ready_reg && !reload;
   assign last_word   = (wr_ptr_reg == WR_LAST);
   assign last_pix    = (rd_ptr_reg == RD_LAST);
   assign rd_word_idx = WA_W'(rd_ptr_reg / RA_W'(PPW));
   assign rd_lane     = LANE_W'(rd_ptr_reg % RA_W'(PPW));

`ifdef VGA_FRAME_BUF_DOUBLE_BUF_EN
   // loads always target the back bank, so display never stalls on reload
   assign rd_en   = (rd_state_reg == R_STREAM) && active;
   assign wr_addr = {~bank_reg, wr_ptr_reg};
   assign rd_addr = {bank_reg, rd_word_idx};
`else
   assign rd_en   = (rd_state_reg == R_STREAM) && active && !reload;
   assign wr_addr = wr_ptr_reg;
   assign rd_addr = rd_word_idx;
`endif

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_addr] <= host.in_data;
      end
      if (rd_en) begin
         rd_word_reg <= mem[rd_addr];
      end
   end

   // byte 0 holds the first pixels; inside a byte the most significant pixel leads
   generate
      for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
         localparam int LSB = (gi / PPB) * 8 + 8 - ((gi % PPB) + 1) * PIX_W;
         assign lanes[gi] = rd_word_reg[LSB +: PIX_W];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_reg    <= W_LOAD;
         rd_state_reg    <= R_IDLE;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         in_ready_reg    <= 1'b0;
         img_ready_reg   <= 1'b0;
         pix_valid_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
         shown_reg       <= 1'b0;
         lane_reg        <= '0;
`ifdef VGA_FRAME_BUF_DOUBLE_BUF_EN
         bank_reg        <= 1'b0;
         pending_reg     <= 1'b0;
`endif
      end else begin
         pix_valid_reg   <= rd_en;
         frame_start_reg <= rd_en && (rd_ptr_reg == '0);
         if (rd_en) begin
            shown_reg  <= 1'b1;
            lane_reg   <= rd_lane;
            rd_ptr_reg <= last_pix ? '0 : rd_ptr_reg + RA_W'(1);
         end

         if (reload) begin
            wr_state_reg <= W_LOAD;
            wr_ptr_reg   <= '0;
            in_ready_reg <= 1'b1;
`ifdef VGA_FRAME_BUF_DOUBLE_BUF_EN
            pending_reg  <= 1'b0;
`else
            img_ready_reg <= 1'b0;
            rd_state_reg  <= R_IDLE;
            rd_ptr_reg    <= '0;
`endif
         end else begin
            case (wr_state_reg)
               W_LOAD: begin
                  in_ready_reg <= 1'b1;
                  if (accept) begin
                     if (last_word) begin
                        wr_ptr_reg <= '0;
`ifdef VGA_FRAME_BUF_DOUBLE_BUF_EN
                        if (!img_ready_reg) begin
                           // nothing on screen yet: show the first image straight away
                           bank_reg      <= ~bank_reg;
                           img_ready_reg <= 1'b1;
                           rd_state_reg  <= R_STREAM;
                        end else begin
                           wr_state_reg <= W_FULL;
                           in_ready_reg <= 1'b0;
                           pending_reg  <= 1'b1;
                        end
`else
                        wr_state_reg  <= W_FULL;
                        in_ready_reg  <= 1'b0;
                        img_ready_reg <= 1'b1;
                        rd_state_reg  <= R_STREAM;
`endif
                     end else begin
                        wr_ptr_reg <= wr_ptr_reg + WA_W'(1);
                     end
                  end
               end
               W_FULL: begin
                  in_ready_reg <= 1'b0;
`ifdef VGA_FRAME_BUF_DOUBLE_BUF_EN
                  // swap on the last pixel so the next pixel 0 comes from the new image
                  if (pending_reg && rd_en && last_pix) begin
                     bank_reg     <= ~bank_reg;
                     pending_reg  <= 1'b0;
                     wr_state_reg <= W_LOAD;
                     in_ready_reg <= 1'b1;
                  end
`endif
               end
               default: wr_state_reg <= W_LOAD;
            endcase
         end
      end
   end

   assign host.in_ready = in_ready_reg;
   assign img_ready     = img_ready_reg;
   assign pix_value     = shown_reg ? lanes[lane_reg] : '0;
   assign pix_valid     = pix_valid_reg;
   assign frame_start   = frame_start_reg;
endmodule

// File: tb/tb_vga_frame_buf.sv
// Bench for vga_frame_buf: a 4-bit/64-pixel instance against a pixel-array reference model,
// plus an 8-bit/16-pixel instance for byte-lane ordering.
module tb_vga_frame_buf;
   localparam int DW  = 32;
   localparam int D4  = 64;
   localparam int NW4 = 8;
   localparam int D8  = 16;
   localparam int NW8 = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vga_frame_buf_if #(.DATA_W(DW)) bus4 ();
   vga_frame_buf_if #(.DATA_W(DW)) bus8 ();

   logic       reload4, active4, img_ready4, pix_valid4, frame_start4;
   logic [3:0] pix_value4;
   logic       reload8, active8, img_ready8, pix_valid8, frame_start8;
   logic [7:0] pix_value8;

   vga_frame_buf #(.PIX_W(4), .DATA_W(DW), .DEPTH(D4)) u_dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .host        (bus4),
      .reload      (reload4),
      .active      (active4),
      .img_ready   (img_ready4),
      .pix_value   (pix_value4),
      .pix_valid   (pix_valid4),
      .frame_start (frame_start4)
   );

   vga_frame_buf #(.PIX_W(8), .DATA_W(DW), .DEPTH(D8)) u_dut8 (
      .clk         (clk),
      .rst_n       (rst_n),
      .host        (bus8),
      .reload      (reload8),
      .active      (active8),
      .img_ready   (img_ready8),
      .pix_value   (pix_value8),
      .pix_valid   (pix_valid8),
      .frame_start (frame_start8)
   );

   int total = 0;
   int bad   = 0;

   // reference model of the 4-bit instance: displayed image as a flat pixel array
   int m_img [D4];
   bit m_loading, m_in_ready, m_ready, m_valid, m_fs;
   int m_wptr, m_idx, m_pix;

   // pixel k of a word: bytes from LSB, most significant pixel of a byte first
   function automatic int unpack(input logic [31:0] w, input int pw, input int k);
      int ppb;
      int sh;
      ppb = 8 / pw;
      sh  = (k / ppb) * 8 + 8 - ((k % ppb) + 1) * pw;
      return int'((w >> sh) & ((32'd1 << pw) - 32'd1));
   endfunction

   task automatic model_reset();
      m_loading  = 1'b1;
      m_in_ready = 1'b0;
      m_ready    = 1'b0;
      m_valid    = 1'b0;
      m_fs       = 1'b0;
      m_wptr     = 0;
      m_idx      = 0;
      m_pix      = 0;
   endtask

   // drive one cycle on the 4-bit instance and advance the model; returns #1 after the edge
   task automatic cycle4(input bit act, input bit vld, input logic [31:0] data, input bit rl);
      active4       = act;
      bus4.in_valid = vld;
      bus4.in_data  = data;
      reload4       = rl;
      @(posedge clk);
      if (rl) begin
         m_loading = 1'b1;
         m_wptr    = 0;
         m_ready   = 1'b0;
         m_idx     = 0;
         m_valid   = 1'b0;
         m_fs      = 1'b0;
      end else begin
         m_valid = m_ready && act;
         m_fs    = m_valid && (m_idx == 0);
         if (m_valid) begin
            m_pix = m_img[m_idx];
            m_idx = (m_idx + 1) % D4;
         end
         if (m_in_ready && vld) begin
            for (int k = 0; k < 8; k++) m_img[m_wptr * 8 + k] = unpack(data, 4, k);
            m_wptr++;
            if (m_wptr == NW4) begin
               m_wptr    = 0;
               m_loading = 1'b0;
               m_ready   = 1'b1;
               m_idx     = 0;
            end
         end
      end
      m_in_ready = m_loading;
      #1;
   endtask

   task automatic test_reset();
      bus4.in_valid = 1'b0; bus4.in_data = '0; reload4 = 1'b0; active4 = 1'b0;
      bus8.in_valid = 1'b0; bus8.in_data = '0; reload8 = 1'b0; active8 = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus4.in_ready, img_ready4, pix_value4, pix_valid4, frame_start4} !== 8'h00) begin
         bad++;
         $display("FAIL reset4 got rdy=%b img=%b pix=%h v=%b fs=%b want all 0",
                  bus4.in_ready, img_ready4, pix_value4, pix_valid4, frame_start4);
      end
      total++;
      if ({bus8.in_ready, img_ready8, pix_value8, pix_valid8, frame_start8} !== 12'h000) begin
         bad++;
         $display("FAIL reset8 got rdy=%b img=%b pix=%h v=%b fs=%b want all 0",
                  bus8.in_ready, img_ready8, pix_value8, pix_valid8, frame_start8);
      end
      rst_n = 1'b1;
      model_reset();
      #1;
      total++;
      if (bus4.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_before_edge got %b want 0", bus4.in_ready);
      end
      cycle4(1'b0, 1'b0, 32'h0, 1'b0);
      total++;
      if (bus4.in_ready !== 1'b1 || bus8.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_release got %b/%b want 1/1", bus4.in_ready, bus8.in_ready);
      end
      $display("reset: in_ready4=%b in_ready8=%b", bus4.in_ready, bus8.in_ready);
   endtask

   task automatic test_load_stream();
      int seq [8];
      int fs_count;
      seq = '{2, 1, 4, 3, 6, 5, 8, 7};
      for (int w = 0; w < NW4; w++) begin
         cycle4(1'b1, 1'b1, 32'h87654321, 1'b0);
         total++;
         if (img_ready4 !== m_ready || bus4.in_ready !== m_in_ready || pix_valid4 !== 1'b0) begin
            bad++;
            $display("FAIL load w=%0d got img=%b rdy=%b v=%b want img=%b rdy=%b v=0",
                     w, img_ready4, bus4.in_ready, pix_valid4, m_ready, m_in_ready);
         end
         $display("load word %0d img_ready=%b in_ready=%b", w, img_ready4, bus4.in_ready);
      end
      fs_count = 0;
      for (int c = 0; c < 140; c++) begin
         cycle4(1'b1, 1'b0, 32'h0, 1'b0);
         if (frame_start4 === 1'b1) fs_count++;
         total++;
         if (pix_valid4 !== m_valid || frame_start4 !== m_fs || pix_value4 !== 4'(m_pix)) begin
            bad++;
            $display("FAIL stream c=%0d got v=%b fs=%b pix=%h want v=%b fs=%b pix=%h",
                     c, pix_valid4, frame_start4, pix_value4, m_valid, m_fs, 4'(m_pix));
         end
         if (c < 8) begin
            total++;
            if (pix_value4 !== 4'(seq[c])) begin
               bad++;
               $display("FAIL lane_order c=%0d got %h want %h", c, pix_value4, 4'(seq[c]));
            end
         end
      end
      total++;
      if (fs_count != 3) begin
         bad++;
         $display("FAIL frame_start_count got %0d want 3", fs_count);
      end
      $display("stream: 140 cycles, frame_start pulses=%0d", fs_count);
   endtask

   task automatic test_active_gaps();
      bit pat [4];
      bit a;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 160; c++) begin
         a = (c < 4) ? pat[c] : 1'($urandom_range(0, 1));
         cycle4(a, 1'b0, 32'h0, 1'b0);
         total++;
         if (pix_valid4 !== m_valid || frame_start4 !== m_fs || pix_value4 !== 4'(m_pix)) begin
            bad++;
            $display("FAIL gaps c=%0d act=%b got v=%b fs=%b pix=%h want v=%b fs=%b pix=%h",
                     c, a, pix_valid4, frame_start4, pix_value4, m_valid, m_fs, 4'(m_pix));
         end
      end
      $display("active gaps: 160 cycles checked");
   endtask

   task automatic test_reload();
      int words;
      bit vld;
      cycle4(1'b0, 1'b0, 32'h0, 1'b1);
      total++;
      if (img_ready4 !== 1'b0 || bus4.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reload_pulse got img=%b rdy=%b want img=0 rdy=1", img_ready4, bus4.in_ready);
      end
      for (int w = 0; w < 3; w++) cycle4(1'($urandom_range(0, 1)), 1'b1, $urandom, 1'b0);
      // word 3 offered together with reload: dropped, load restarts
      cycle4(1'b0, 1'b1, $urandom, 1'b1);
      words = 0;
      for (int c = 0; c < 100 && !m_ready; c++) begin
         vld = 1'($urandom_range(0, 3) != 0);
         if (vld) words++;
         cycle4(1'($urandom_range(0, 1)), vld, $urandom, 1'b0);
         total++;
         if (img_ready4 !== m_ready || bus4.in_ready !== m_in_ready || pix_valid4 !== m_valid) begin
            bad++;
            $display("FAIL reload_load c=%0d got img=%b rdy=%b v=%b want img=%b rdy=%b v=%b",
                     c, img_ready4, bus4.in_ready, pix_valid4, m_ready, m_in_ready, m_valid);
         end
      end
      total++;
      if (img_ready4 !== 1'b1 || words != 8) begin
         bad++;
         $display("FAIL reload_complete got img=%b words=%0d want img=1 words=8", img_ready4, words);
      end
      $display("reload: image complete after %0d further words", words);
      for (int c = 0; c < 150; c++) begin
         cycle4(1'($urandom_range(0, 1)), c < 6, $urandom, 1'b0);
         total++;
         if (pix_valid4 !== m_valid || frame_start4 !== m_fs || pix_value4 !== 4'(m_pix)
             || bus4.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reload_stream c=%0d got v=%b fs=%b pix=%h rdy=%b want v=%b fs=%b pix=%h rdy=0",
                     c, pix_valid4, frame_start4, pix_value4, bus4.in_ready, m_valid, m_fs, 4'(m_pix));
         end
      end
      bus4.in_valid = 1'b0;
   endtask

   task automatic test_pix8();
      logic [31:0] w8 [NW8];
      int exp_pix;
      w8[0] = 32'h44332211;
      for (int w = 1; w < NW8; w++) w8[w] = $urandom;
      active8 = 1'b0;
      for (int w = 0; w < NW8; w++) begin
         bus8.in_valid = 1'b1;
         bus8.in_data  = w8[w];
         @(posedge clk);
         #1;
         total++;
         if (img_ready8 !== (w == NW8 - 1)) begin
            bad++;
            $display("FAIL pix8_load w=%0d got img=%b want %b", w, img_ready8, (w == NW8 - 1));
         end
      end
      bus8.in_valid = 1'b0;
      active8 = 1'b1;
      for (int c = 0; c < 2 * D8 + 4; c++) begin
         @(posedge clk);
         #1;
         exp_pix = unpack(w8[(c % D8) / 4], 8, c % 4);
         total++;
         if (pix_value8 !== 8'(exp_pix) || pix_valid8 !== 1'b1 || frame_start8 !== (c % D8 == 0)) begin
            bad++;
            $display("FAIL pix8 c=%0d got pix=%h v=%b fs=%b want pix=%h v=1 fs=%b",
                     c, pix_value8, pix_valid8, frame_start8, 8'(exp_pix), (c % D8 == 0));
         end
         if (c < 4) begin
            total++;
            if (pix_value8 !== 8'((c + 1) * 8'h11)) begin
               bad++;
               $display("FAIL pix8_order c=%0d got %h want %h", c, pix_value8, 8'((c + 1) * 8'h11));
            end
         end
      end
      active8 = 1'b0;
      $display("pix8: %0d pixels checked", 2 * D8 + 4);
   endtask

`ifdef VGA_FRAME_BUF_DOUBLE_BUF_EN
   task automatic test_double_buf();
      int p;
      int loaded;
      bit pend, swapped, exp_ir, offer, exp_fs;
      logic [3:0] exp_val;
      active4 = 1'b0;
      reload4 = 1'b0;
      for (int w = 0; w < NW4; w++) begin
         bus4.in_valid = 1'b1;
         bus4.in_data  = 32'h11111111;
         @(posedge clk);
         #1;
      end
      bus4.in_valid = 1'b0;
      total++;
      if (img_ready4 !== 1'b1 || bus4.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL db_first got img=%b rdy=%b want 1/1", img_ready4, bus4.in_ready);
      end
      p = 0; loaded = 0; pend = 1'b0; swapped = 1'b0; exp_ir = 1'b1;
      for (int c = 0; c < 200; c++) begin
         offer = (c >= 20) && (loaded < NW4);
         active4       = 1'b1;
         bus4.in_valid = offer;
         bus4.in_data  = 32'h22222222;
         @(posedge clk);
         #1;
         if (offer && exp_ir) begin
            loaded++;
            if (loaded == NW4) pend = 1'b1;
         end
         exp_val = swapped ? 4'h2 : 4'h1;
         exp_fs  = (p == 0);
         if (pend && p == D4 - 1) begin
            pend    = 1'b0;
            swapped = 1'b1;
         end
         p = (p + 1) % D4;
         exp_ir = !pend;
         total++;
         if (pix_value4 !== exp_val || pix_valid4 !== 1'b1 || frame_start4 !== exp_fs
             || bus4.in_ready !== exp_ir || img_ready4 !== 1'b1) begin
            bad++;
            $display("FAIL db c=%0d got pix=%h v=%b fs=%b rdy=%b img=%b want pix=%h v=1 fs=%b rdy=%b img=1",
                     c, pix_value4, pix_valid4, frame_start4, bus4.in_ready, img_ready4,
                     exp_val, exp_fs, exp_ir);
         end
      end
      bus4.in_valid = 1'b0;
      total++;
      if (!swapped) begin
         bad++;
         $display("FAIL db_swap got swapped=0 want 1");
      end
      $display("double buffer: 200 cycles checked, swapped=%b", swapped);
   endtask
`endif

   initial begin
      test_reset();
`ifdef VGA_FRAME_BUF_DOUBLE_BUF_EN
      test_double_buf();
`else
      test_load_stream();
      test_active_gaps();
      test_reload();
`endif
      test_pix8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
